lsu_dbus_ctrl: RTL and testbench

//  Load/store unit data-bus master. Consumes the memory op registered by the EX->MEM pipeline stage.

---
 rtl/lsu_dbus_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_lsu_dbus_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dbus_ctrl.sv
// lsu_dbus_ctrl -- load/store unit data-bus master.
//
// Takes the memory op held in the EX->MEM register and runs exactly one
// req/gnt/rvalid transaction for it. Upstream stages are stalled while the
// op is outstanding. Store data is replicated into byte lanes, and load data
// is shifted down and sign/zero extended. Bus errors and timeouts are
// reported as access faults.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word ops trap (cause 4/6) without touching the bus
//   undefined : low address bits are forced to natural alignment for the access
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   flush_i                    pipeline flush
//   valid_i .. rd_addr_i       memory op from the EX->MEM register
//   stall_req_o                combinational upstream hold
//   dbus_*                     data bus master (req/gnt/rvalid handshake)
//   rd_we_o/rd_addr_o/rd_wdata_o  load writeback (1-cycle pulse)
//   done_o                     op retired without fault (1-cycle pulse)
//   exc_valid_o/cause/tval     op faulted (1-cycle pulse)
module lsu_dbus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_req_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_wdata_o,
  output logic        done_o,
  output logic        exc_valid_o,
  output logic [3:0]  exc_cause_o,
  output logic [31:0] exc_tval_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int unsigned   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TERM  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic          TO_EN = (TIMEOUT > 0);

  // Byte offset actually used on the bus: halves and words are forced to
  // natural alignment (a no-op for ops that are already aligned).
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          op_we_r, op_we_s, op_uns_r, op_uns_s;
  logic [1:0]    op_size_r, op_size_s;
  logic [31:0]   op_addr_r, op_addr_s;
  logic [4:0]    op_rd_r, op_rd_s;
  logic          req_s, bus_we_s, rd_we_s, done_s, exc_valid_s;
  logic [31:0]   bus_addr_s, bus_wdata_s, rd_wdata_s, exc_tval_s;
  logic [3:0]    be_s, exc_cause_s;
  logic [4:0]    rd_addr_s;
  logic          misalign_s, term_s;

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = (size_i == 2'b01) ? addr_i[0]
                    : (size_i[1] ? (addr_i[1:0] != 2'b00) : 1'b0);
`else
  assign misalign_s = 1'b0;
`endif

  // Terminal count: this is the TIMEOUT-th cycle spent with the op on the bus.
  assign term_s = TO_EN && (cnt_r == TERM);

  // State, op latch and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      op_we_r      <= 1'b0;
      op_uns_r     <= 1'b0;
      op_size_r    <= 2'b00;
      op_addr_r    <= 32'h0000_0000;
      op_rd_r      <= 5'd0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'h0000_0000;
      dbus_be_o    <= 4'b0000;
      dbus_wdata_o <= 32'h0000_0000;
      rd_we_o      <= 1'b0;
      rd_addr_o    <= 5'd0;
      rd_wdata_o   <= 32'h0000_0000;
      done_o       <= 1'b0;
      exc_valid_o  <= 1'b0;
      exc_cause_o  <= 4'd0;
      exc_tval_o   <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      op_we_r      <= op_we_s;
      op_uns_r     <= op_uns_s;
      op_size_r    <= op_size_s;
      op_addr_r    <= op_addr_s;
      op_rd_r      <= op_rd_s;
      dbus_req_o   <= req_s;
      dbus_we_o    <= bus_we_s;
      dbus_addr_o  <= bus_addr_s;
      dbus_be_o    <= be_s;
      dbus_wdata_o <= bus_wdata_s;
      rd_we_o      <= rd_we_s;
      rd_addr_o    <= rd_addr_s;
      rd_wdata_o   <= rd_wdata_s;
      done_o       <= done_s;
      exc_valid_o  <= exc_valid_s;
      exc_cause_o  <= exc_cause_s;
      exc_tval_o   <= exc_tval_s;
    end
  end

  // Next-state, next-output and stall logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    op_we_s     = op_we_r;
    op_uns_s    = op_uns_r;
    op_size_s   = op_size_r;
    op_addr_s   = op_addr_r;
    op_rd_s     = op_rd_r;
    req_s       = dbus_req_o;
    bus_we_s    = dbus_we_o;
    bus_addr_s  = dbus_addr_o;
    be_s        = dbus_be_o;
    bus_wdata_s = dbus_wdata_o;
    rd_we_s     = 1'b0;
    rd_addr_s   = rd_addr_o;
    rd_wdata_s  = rd_wdata_o;
    done_s      = 1'b0;
    exc_valid_s = 1'b0;
    exc_cause_s = exc_cause_o;
    exc_tval_s  = exc_tval_o;
    stall_req_o = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (misalign_s) begin
            exc_valid_s = 1'b1;
            exc_cause_s = we_i ? 4'd6 : 4'd4;
            exc_tval_s  = addr_i;
          end else begin
            stall_req_o = 1'b1;
            state_s     = ST_REQ;
            cnt_s       = {CW{1'b0}};
            op_we_s     = we_i;
            op_uns_s    = unsigned_i;
            op_size_s   = size_i;
            op_addr_s   = addr_i;
            op_rd_s     = rd_addr_i;
            req_s       = 1'b1;
            bus_we_s    = we_i;
            bus_addr_s  = {addr_i[31:2], 2'b00};
            be_s        = byte_en(size_i, lane_off(size_i, addr_i[1:0]));
            bus_wdata_s = store_lanes(size_i, wdata_i);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        stall_req_o = 1'b1;
        cnt_s       = cnt_r + CW'(1);
        if (flush_i) begin
          // A granted request still owes us a response, which must be drained.
          req_s   = 1'b0;
          state_s = dbus_gnt_i ? ST_DRAIN : ST_IDLE;
        end else if (term_s) begin
          req_s       = 1'b0;
          state_s     = ST_IDLE;
          exc_valid_s = 1'b1;
          exc_cause_s = op_we_r ? 4'd7 : 4'd5;
          exc_tval_s  = op_addr_r;
        end else if (dbus_gnt_i) begin
          req_s   = 1'b0;
          state_s = ST_RESP;
        end else begin
          state_s = ST_REQ;
        end
      end

      ST_RESP: begin
        stall_req_o = !dbus_rvalid_i;
        cnt_s       = cnt_r + CW'(1);
        // rvalid is checked before the terminal count so a response on the
        // last allowed cycle still completes normally.
        if (dbus_rvalid_i) begin
          state_s = ST_IDLE;
          if (flush_i) begin
            // Response arrived together with the flush: nothing to drain, discard it.
            done_s = 1'b0;
          end else if (dbus_err_i) begin
            exc_valid_s = 1'b1;
            exc_cause_s = op_we_r ? 4'd7 : 4'd5;
            exc_tval_s  = op_addr_r;
          end else begin
            done_s     = 1'b1;
            rd_we_s    = !op_we_r;
            rd_addr_s  = op_we_r ? rd_addr_o : op_rd_r;
            rd_wdata_s = op_we_r ? rd_wdata_o
                       : load_extend(op_size_r, op_uns_r,
                                     lane_off(op_size_r, op_addr_r[1:0]), dbus_rdata_i);
          end
        end else if (flush_i) begin
          state_s = ST_DRAIN;
        end else if (term_s) begin
          state_s     = ST_IDLE;
          exc_valid_s = 1'b1;
          exc_cause_s = op_we_r ? 4'd7 : 4'd5;
          exc_tval_s  = op_addr_r;
        end else begin
          state_s = ST_RESP;
        end
      end

      ST_DRAIN: begin
        stall_req_o = 1'b1;
        cnt_s       = cnt_r + CW'(1);
        // The timeout also bounds the drain so a dead bus cannot wedge the
        // pipeline; the op was already flushed, so it exits silently.
        if (dbus_rvalid_i || term_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Self-checking bench for lsu_dbus_ctrl: directed vector table, hand-written
// corner sequences (misalignment, timeout, flush, reset) and randomized ops
// compared against a byte-level reference model.
module tb_lsu_dbus_ctrl;

  logic        clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        stall_req_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0, dbus_err_i = 1'b0;
  logic [31:0] dbus_rdata_i = 32'h0;
  logic        rd_we_o, done_o, exc_valid_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o, exc_tval_o;
  logic [3:0]  exc_cause_o;

  int checks = 0;
  int errors = 0;

  // Observations captured by run_op.
  logic [31:0] obs_addr, obs_wdata, obs_rd_wdata, obs_tval;
  logic [3:0]  obs_be, obs_cause;
  logic [4:0]  obs_rd_addr;
  logic        obs_we, obs_rd_we, obs_done, obs_exc, obs_req_ok, obs_req_low;
  int          obs_stalls;

  lsu_dbus_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_addr_i(rd_addr_i), .stall_req_o(stall_req_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i), .rd_we_o(rd_we_o),
    .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o), .done_o(done_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int m_bytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    else if (size == 2'd1) return 2;
    else return 4;
  endfunction

  function automatic int m_off(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = m_bytes(size);
    return (int'(addr % 32'd4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int o, n;
    o = m_off(size, addr);
    n = m_bytes(size);
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = m_bytes(size);
    for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] v;
    int o, n;
    o = m_off(size, addr);
    n = m_bytes(size);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = d[8*(o+k) +: 8];
    if (!uns && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // One full op: accept, gd idle-grant cycles, rd_dly idle-response cycles.
  // Ends at the falling edge of the cycle carrying the result pulses.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int gd, input int rd_dly, input logic [31:0] rdata, input logic err);
    valid_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
    addr_i = addr; wdata_i = wdata; rd_addr_i = rd;
    obs_req_ok = 1'b1; obs_req_low = 1'b1;
    @(negedge clk_i);
    obs_stalls = int'(stall_req_o);
    step();
    for (int g = 0; g <= gd; g++) begin
      dbus_gnt_i = (g == gd);
      @(negedge clk_i);
      obs_stalls += int'(stall_req_o);
      if (g == 0) begin
        obs_be = dbus_be_o; obs_addr = dbus_addr_o; obs_wdata = dbus_wdata_o; obs_we = dbus_we_o;
      end
      obs_req_ok = obs_req_ok & dbus_req_o & (dbus_be_o == obs_be) & (dbus_addr_o == obs_addr);
      step();
    end
    dbus_gnt_i = 1'b0;
    for (int r = 0; r <= rd_dly; r++) begin
      dbus_rvalid_i = (r == rd_dly);
      dbus_rdata_i  = (r == rd_dly) ? rdata : 32'h0BAD_0BAD;
      dbus_err_i    = (r == rd_dly) ? err : 1'b0;
      @(negedge clk_i);
      obs_stalls += int'(stall_req_o);
      obs_req_low = obs_req_low & ~dbus_req_o;
      step();
    end
    dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    obs_rd_we = rd_we_o; obs_rd_addr = rd_addr_o; obs_rd_wdata = rd_wdata_o;
    obs_done = done_o; obs_exc = exc_valid_o; obs_cause = exc_cause_o; obs_tval = exc_tval_o;
  endtask

  task automatic check_bus(input string n, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic we, input int stalls);
    check({n, " addr"}, obs_addr, a);
    check({n, " be"}, obs_be, be);
    check({n, " bus_we"}, obs_we, we);
    if (we) check({n, " wdata"}, obs_wdata, wd);
    check({n, " stall_cycles"}, obs_stalls, stalls);
    check({n, " req_held"}, obs_req_ok, 1'b1);
    check({n, " req_dropped"}, obs_req_low, 1'b1);
  endtask

  task automatic check_res(input string n, input logic rdwe, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic dn, input logic ex,
                           input logic [3:0] cause, input logic [31:0] tval);
    check({n, " rd_we"}, obs_rd_we, rdwe);
    check({n, " done"}, obs_done, dn);
    check({n, " exc_valid"}, obs_exc, ex);
    if (rdwe) begin
      check({n, " rd_wdata"}, obs_rd_wdata, rdata);
      check({n, " rd_addr"}, obs_rd_addr, rd);
    end
    if (ex) begin
      check({n, " exc_cause"}, obs_cause, cause);
      check({n, " exc_tval"}, obs_tval, tval);
    end
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic err;
    logic [3:0] be; logic [31:0] bus_wdata; logic rd_we; logic [31:0] rd_data;
    logic done; logic exc; logic [3:0] cause;
  } vec_t;

  vec_t tv[11];
  logic pulses;
  int   n;

  initial begin
    // we  size  uns addr          wdata          rdata          err   be       bus_wdata      rd_we rd_data        done exc cause
    tv[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,          32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,          1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd0};
    tv[1]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,          32'h80112233, 1'b0, 4'b1000, 32'h0,          1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 4'd0};
    tv[2]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,          32'h80112233, 1'b0, 4'b1000, 32'h0,          1'b1, 32'h00000080, 1'b1, 1'b0, 4'd0};
    tv[3]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD,   32'h0,        1'b0, 4'b1100, 32'hABCDABCD,   1'b0, 32'h0,        1'b1, 1'b0, 4'd0};
    tv[4]  = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,          32'h80011234, 1'b0, 4'b1100, 32'h0,          1'b1, 32'hFFFF8001, 1'b1, 1'b0, 4'd0};
    tv[5]  = '{1'b0, 2'd1, 1'b1, 32'h000, 32'h0,          32'h1234F00D, 1'b0, 4'b0011, 32'h0,          1'b1, 32'h0000F00D, 1'b1, 1'b0, 4'd0};
    tv[6]  = '{1'b1, 2'd0, 1'b0, 32'h201, 32'h1234565A,   32'h0,        1'b0, 4'b0010, 32'h5A5A5A5A,   1'b0, 32'h0,        1'b1, 1'b0, 4'd0};
    tv[7]  = '{1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D,   32'h0,        1'b1, 4'b1111, 32'hCAFEF00D,   1'b0, 32'h0,        1'b0, 1'b1, 4'd7};
    tv[8]  = '{1'b0, 2'd2, 1'b0, 32'h304, 32'h0,          32'h12345678, 1'b1, 4'b1111, 32'h0,          1'b0, 32'h0,        1'b0, 1'b1, 4'd5};
    tv[9]  = '{1'b0, 2'd0, 1'b0, 32'h102, 32'h0,          32'h007F0000, 1'b0, 4'b0100, 32'h0,          1'b1, 32'h0000007F, 1'b1, 1'b0, 4'd0};
    tv[10] = '{1'b0, 2'd3, 1'b0, 32'h400, 32'h0,          32'h11223344, 1'b0, 4'b1111, 32'h0,          1'b1, 32'h11223344, 1'b1, 1'b0, 4'd0};

    // Reset state.
    #3;
    check("reset stall", stall_req_o, 1'b0);
    check("reset bus", {dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o}, 64'h0);
    check("reset wdata", dbus_wdata_o, 32'h0);
    check("reset pulses", {rd_we_o, done_o, exc_valid_o, exc_cause_o, rd_addr_o}, 64'h0);
    check("reset data", {rd_wdata_o, exc_tval_o}, 64'h0);
    @(negedge clk_i); rst_i = 1'b0;

    // Directed vector table: grant immediately, response one cycle later.
    for (int i = 0; i < 11; i++) begin
      step();
      run_op(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 5'(i + 1),
             0, 1, tv[i].rdata, tv[i].err);
      check_bus($sformatf("vec%0d", i), {tv[i].addr[31:2], 2'b00}, tv[i].be,
                tv[i].bus_wdata, tv[i].we, 3);
      check_res($sformatf("vec%0d", i), tv[i].rd_we, 5'(i + 1), tv[i].rd_data, tv[i].done,
                tv[i].exc, tv[i].cause, tv[i].addr);
      step();
      @(negedge clk_i);
      check($sformatf("vec%0d pulse_width", i), {rd_we_o, done_o, exc_valid_o}, 3'b000);
    end

    // Misaligned word/half.
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 2; i++) begin
      step();
      valid_i = 1'b1; we_i = (i == 1); size_i = (i == 1) ? 2'd1 : 2'd2;
      addr_i = (i == 1) ? 32'h203 : 32'h101; unsigned_i = 1'b0;
      @(negedge clk_i);
      check($sformatf("mis%0d stall", i), stall_req_o, 1'b0);
      step();
      valid_i = 1'b0;
      @(negedge clk_i);
      check($sformatf("mis%0d no_req", i), dbus_req_o, 1'b0);
      check($sformatf("mis%0d exc", i), exc_valid_o, 1'b1);
      check($sformatf("mis%0d cause", i), exc_cause_o, (i == 1) ? 4'd6 : 4'd4);
      check($sformatf("mis%0d tval", i), exc_tval_o, (i == 1) ? 32'h203 : 32'h101);
    end
`else
    step();
    run_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 0, 0, 32'hA1B2C3D4, 1'b0);
    check_bus("mis_lw", 32'h100, 4'b1111, 32'h0, 1'b0, 2);
    check_res("mis_lw", 1'b1, 5'd3, 32'hA1B2C3D4, 1'b1, 1'b0, 4'd0, 32'h0);
    step();
    run_op(1'b1, 2'd1, 1'b0, 32'h203, 32'h0000BEEF, 5'd0, 1, 0, 32'h0, 1'b0);
    check_bus("mis_sh", 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1, 3);
    check_res("mis_sh", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
`endif

    // Timeout: grant never comes.
    step();
    valid_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h500; rd_addr_i = 5'd7;
    step();
    valid_i = 1'b0;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (!dbus_req_o || n > 400) break;
      n++;
      step();
    end
    check("timeout req_cycles", n, 255);
    check("timeout exc", exc_valid_o, 1'b1);
    check("timeout cause", exc_cause_o, 4'd5);
    check("timeout tval", exc_tval_o, 32'h500);
    check("timeout stall", stall_req_o, 1'b0);
    step(); dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h55AA55AA;
    step(); dbus_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("late_rvalid ignored", {rd_we_o, done_o, exc_valid_o, dbus_req_o}, 4'b0000);

    // Flush in RESP, error response two cycles later is discarded.
    step();
    valid_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h600; rd_addr_i = 5'd9;
    step(); valid_i = 1'b0; dbus_gnt_i = 1'b1;
    step(); dbus_gnt_i = 1'b0; flush_i = 1'b1;
    pulses = 1'b0;
    @(negedge clk_i); pulses = pulses | rd_we_o | done_o | exc_valid_o;
    step(); flush_i = 1'b0;
    @(negedge clk_i); pulses = pulses | rd_we_o | done_o | exc_valid_o;
    check("drain stall", stall_req_o, 1'b1);
    step(); dbus_rvalid_i = 1'b1; dbus_err_i = 1'b1;
    @(negedge clk_i); pulses = pulses | rd_we_o | done_o | exc_valid_o;
    for (int k = 0; k < 2; k++) begin
      step(); dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
      @(negedge clk_i); pulses = pulses | rd_we_o | done_o | exc_valid_o;
    end
    check("drain no_pulses", pulses, 1'b0);
    step();
    run_op(1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 5'd10, 0, 1, 32'h13579BDF, 1'b0);
    check_bus("after_drain", 32'h604, 4'b1111, 32'h0, 1'b0, 3);
    check_res("after_drain", 1'b1, 5'd10, 32'h13579BDF, 1'b1, 1'b0, 4'd0, 32'h0);

    // Flush in REQ without grant.
    step();
    valid_i = 1'b1; we_i = 1'b1; size_i = 2'd2; addr_i = 32'h700;
    step(); valid_i = 1'b0; flush_i = 1'b1;
    step(); flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_req idle", {dbus_req_o, stall_req_o, done_o, exc_valid_o}, 4'b0000);

    // Async reset mid-op.
    step();
    valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h800;
    step(); valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("async_reset req", dbus_req_o, 1'b0);
    check("async_reset stall", stall_req_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic rwe, runs, rerr;
      logic [1:0] rsz;
      logic [31:0] ra, rwd, rrd;
      int rgd, rrl;
      rwe = 1'($urandom_range(0, 1)); runs = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3)); ra = $urandom; rwd = $urandom; rrd = $urandom;
      rerr = ($urandom_range(0, 7) == 0);
      rgd = $urandom_range(0, 3); rrl = $urandom_range(0, 3);
`ifdef MISALIGN_TRAP_EN
      ra = ra & ~(32'(m_bytes(rsz)) - 32'd1);
`endif
      step();
      run_op(rwe, rsz, runs, ra, rwd, 5'(i), rgd, rrl, rrd, rerr);
      check_bus($sformatf("rnd%0d", i), {ra[31:2], 2'b00}, m_be(rsz, ra), m_wdata(rsz, rwd),
                rwe, 2 + rgd + rrl);
      check_res($sformatf("rnd%0d", i), !rwe && !rerr, 5'(i), m_load(rsz, runs, ra, rrd),
                !rerr, rerr, rwe ? 4'd7 : 4'd5, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
